// File: rtl/state_reg_arbiter.sv
// state_reg_arbiter: round-robin write arbiter that owns a single shared state
// register. One requester is granted per two-cycle write slot. The winner's data
// is latched into reg_q, and a one-cycle one-hot grant is returned.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   req       in   [NUM_REQ]         request, bit i = requester i
//   req_data  in   [NUM_REQ*DATA_W]  requester i data at [i*DATA_W +: DATA_W]
//   gnt       out  [NUM_REQ]         registered one-hot grant, one cycle per write
//   gnt_id    out  [IDW]             index of the most recent grantee
//   reg_q     out  [DATA_W]          shared register contents
//   busy      out  1                 high in the ACK cycle (requests not sampled)
//   wr_count  out  [16]              completed writes, wraps 0xFFFF -> 0x0000
module state_reg_arbiter #(
    parameter int unsigned          NUM_REQ = 4,
    parameter int unsigned          DATA_W  = 8,
    parameter logic [DATA_W-1:0]    RST_VAL = '0,
    localparam int unsigned         IDW     = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [IDW-1:0]              gnt_id,
    output logic [DATA_W-1:0]           reg_q,
    output logic                        busy,
    output logic [15:0]                 wr_count
);

    localparam int unsigned CNT_W = 16;
    // One extra bit so ptr + offset can be formed before wrapping.
    localparam int unsigned CW    = IDW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_d;
    logic [IDW-1:0]      gnt_id_d;
    logic [DATA_W-1:0]   reg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                win_found;
    logic [IDW-1:0]      win_idx;
    logic [CW-1:0]       cand;
    logic [DATA_W-1:0]   win_data;
    logic [IDW-1:0]      win_next;

    // Round-robin search: first set req bit at or above ptr, wrapping to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            cand = {1'b0, ptr_q} + CW'(off);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!win_found && req[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    // Winner's data word and the pointer value that demotes the winner.
    always_comb begin
        win_data = req_data[32'(win_idx) * DATA_W +: DATA_W];
        win_next = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        gnt_id_d = gnt_id;
        reg_d    = reg_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = ACK;
                    gnt_d    = NUM_REQ'(1) << win_idx;
                    gnt_id_d = win_idx;
                    reg_d    = win_data;
                    ptr_d    = win_next;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            reg_q   <= RST_VAL;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            reg_q   <= reg_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == ACK);
    assign wr_count = cnt_q;

    // Grant sanity: at most one bit, never two cycles in a row, only in ACK.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_no_b2b: assert property (@(posedge clk) disable iff (rst) (|gnt) |=> (gnt == '0));
    a_gnt_busy:   assert property (@(posedge clk) disable iff (rst) ((|gnt) == busy));

endmodule

// File: doc/state_reg_arbiter.md
# state_reg_arbiter

Round-robin write arbiter for a single shared state register built from synchronous D flip-flops. Up to NUM_REQ requesters each present a data word with a request line. The block grants exactly one writer per write slot, latches that writer's data into the register and returns a one-cycle grant. It sits between the per-site simulation engines and the common state flop bank, and is the only agent allowed to update that register.

## Interface
- NUM_REQ, 4, number of requesters (legal 2..16)
- DATA_W, 8, register width in bits
- RST_VAL, 0, value loaded into the register on reset (DATA_W bits)
- IDW, $clog2(NUM_REQ), width of gnt_id (derived, not overridable)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  request, bit i = requester i
- req_data  in  NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  registered one-hot grant, high exactly one cycle per write
- gnt_id  out  IDW  index of the most recent grantee, held until next grant
- reg_q  out  DATA_W  shared register contents
- busy  out  1  high in ACK state; no request is sampled that cycle
- wr_count  out  16  number of completed writes, wraps 0xFFFF -> 0x0000

## Operation
- Two-state FSM: IDLE, ACK.
- IDLE, no req bit set: hold all state; gnt = 0.
- IDLE, any req bit set: select winner w by round-robin, starting search at ptr and going upward, wrapping NUM_REQ-1 -> 0. On the edge: reg_q <= req_data[w], gnt <= one-hot(w), gnt_id <= w, ptr <= (w+1) mod NUM_REQ, wr_count <= wr_count+1, state <= ACK.
- ACK: gnt <= 0, state <= IDLE. req is ignored; reg_q, gnt_id, ptr and wr_count hold.
- busy = (state == ACK); combinational from the state flop.
- Requester contract: assert req with stable req_data and hold both until gnt[i] is seen high. Drop req in the gnt cycle. A req still high in the IDLE cycle after ACK is a new request.
- Round-robin fairness: the most recent grantee has lowest priority on the next arbitration. Requester i waits at most 2*(NUM_REQ-1) cycles from its first IDLE with req high to its grant.
- req bits of index >= NUM_REQ do not exist. Data bits of non-winning requesters never reach reg_q.
- Reset (rst high at an edge, any state): reg_q <= RST_VAL, gnt <= 0, gnt_id <= 0, ptr <= 0, wr_count <= 0, state <= IDLE. req is ignored while rst is high. Reset in ACK cancels nothing already written but clears reg_q to RST_VAL.

## Timing
- Reset values: reg_q = RST_VAL, gnt = 0, gnt_id = 0, busy = 0, wr_count = 0.
- Latency: req sampled high in IDLE cycle t gives gnt, reg_q, gnt_id and wr_count updated and visible in cycle t+1 (busy = 1). Cycle t+2 is IDLE again.
- Peak throughput: one write per 2 cycles. Continuous requests give gnt high every other cycle.
- gnt is never high in two consecutive cycles. Never more than one gnt bit is high.
- The first grant after reset goes to the lowest-index active requester (ptr = 0).

## Test plan
- Reset: drive rst 3 cycles with random req -> reg_q = RST_VAL, gnt = 0, wr_count = 0, busy = 0 throughout and 1 cycle after release.
- Single requester: req = 4'b0100, data2 = 0xA5 -> next cycle gnt = 4'b0100, gnt_id = 2, reg_q = 0xA5, wr_count = 1, busy = 1. The following cycle gnt = 0.
- All four requesting continuously, data_i = 0x10+i -> grants 0,1,2,3,0,... every second cycle. reg_q follows 0x10,0x11,0x12,0x13,0x10. wr_count increments by 1 per grant.
- Fairness after wrap: grant 3, then req = 4'b1001 -> next grant goes to 0, then 3.
- Request arriving in ACK: req1 rises during busy = 1 -> not granted that cycle; granted in the cycle after the next IDLE edge.
- Reset mid-ACK plus counter wrap: preload wr_count to 0xFFFF via 65535 writes, then one more write -> wr_count = 0x0000. Assert rst during ACK -> IDLE next cycle, reg_q = RST_VAL, ptr = 0 (next grant to lowest active index).
